// File: rtl/gcd_lcm_unit.sv
// gcd_lcm_unit: multi-cycle GCD (binary/Stein) or LCM (GCD, restoring
// division, shift-add multiply) of two unsigned WIDTH-bit operands.
// Handshake: start is taken whenever the unit is not busy, including the
// DONE cycle, which allows back-to-back operations. result/err are
// registered and hold their value until the next completed operation.
module gcd_lcm_unit #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result,
    output logic                 err
);

    localparam int KW = $clog2(WIDTH) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GCD,
        S_DIV,
        S_MUL,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_next;

    logic [WIDTH-1:0]      r_x;
    logic [WIDTH-1:0]      r_y;
    logic [WIDTH-1:0]      r_a;
    logic [WIDTH-1:0]      r_b;
    logic [WIDTH-1:0]      r_g;
    logic [WIDTH-1:0]      r_q;
    logic [WIDTH-1:0]      r_rem;
    logic [2*WIDTH-1:0]    r_acc;
    logic [KW-1:0]         r_k;
    logic [KW-1:0]         r_cnt;
    logic                  r_mode;

    logic                  w_accept;
    logic                  w_zero;
    logic                  w_eq;
    logic                  w_last;
    logic [WIDTH-1:0]      w_g;
    logic [WIDTH:0]        w_rem_sh;
    logic                  w_ge;
    logic [WIDTH-1:0]      w_rem_sub;
    logic [WIDTH-1:0]      w_rem_nxt;
    logic [2*WIDTH-1:0]    w_acc_nxt;

    // A start is taken in IDLE and in DONE; zero operands bypass iteration.
    assign w_accept  = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_zero    = (a == '0) || (b == '0);
    assign w_eq      = (r_x == r_y);
    assign w_g       = r_x << r_k;
    assign w_last    = (r_cnt == KW'(WIDTH - 1));

    // Restoring division: dividend bits leave r_q at the MSB while quotient
    // bits enter at the LSB. The remainder stays below g, so WIDTH bits
    // suffice for the difference.
    assign w_rem_sh  = {r_rem, r_q[WIDTH-1]};
    assign w_ge      = (w_rem_sh >= {1'b0, r_g});
    assign w_rem_sub = w_rem_sh[WIDTH-1:0] - r_g;
    assign w_rem_nxt = w_ge ? w_rem_sub : w_rem_sh[WIDTH-1:0];

    // MSB-first shift-add product of the quotient and the latched B operand.
    assign w_acc_nxt = (r_acc << 1)
                     + (r_q[WIDTH-1] ? {{WIDTH{1'b0}}, r_b} : {2*WIDTH{1'b0}});

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = w_zero ? S_DONE : S_GCD;
                end
            end
            S_GCD: begin
                busy = 1'b1;
                if (w_eq) begin
                    w_next = r_mode ? S_DIV : S_DONE;
                end
            end
            S_DIV: begin
                busy = 1'b1;
                if (w_last) begin
                    w_next = S_MUL;
                end
            end
            S_MUL: begin
                busy = 1'b1;
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    w_next = w_zero ? S_DONE : S_GCD;
                end else begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Result and error flag: written only on the edge that enters DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            result <= '0;
            err    <= 1'b0;
        end else if (w_accept && w_zero) begin
            result <= mode ? {2*WIDTH{1'b0}} : {{WIDTH{1'b0}}, a | b};
            err    <= !mode && (a == '0) && (b == '0);
        end else if ((r_state == S_GCD) && w_eq && !r_mode) begin
            result <= {{WIDTH{1'b0}}, w_g};
            err    <= 1'b0;
        end else if ((r_state == S_MUL) && w_last) begin
            result <= w_acc_nxt;
            err    <= 1'b0;
        end
    end

    // Iteration datapath: operand latch, Stein steps, division, multiply.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_x    <= a;
            r_y    <= b;
            r_a    <= a;
            r_b    <= b;
            r_mode <= mode;
            r_k    <= '0;
        end else begin
            case (r_state)
                S_GCD: begin
                    if (w_eq) begin
                        r_g   <= w_g;
                        r_rem <= '0;
                        r_q   <= r_a;
                        r_cnt <= '0;
                    end else if (!r_x[0] && !r_y[0]) begin
                        r_x <= r_x >> 1;
                        r_y <= r_y >> 1;
                        r_k <= r_k + 1'b1;
                    end else if (!r_x[0]) begin
                        r_x <= r_x >> 1;
                    end else if (!r_y[0]) begin
                        r_y <= r_y >> 1;
                    end else if (r_x > r_y) begin
                        r_x <= (r_x - r_y) >> 1;
                    end else begin
                        r_y <= (r_y - r_x) >> 1;
                    end
                end
                S_DIV: begin
                    r_rem <= w_rem_nxt;
                    r_q   <= {r_q[WIDTH-2:0], w_ge};
                    if (w_last) begin
                        r_cnt <= '0;
                        r_acc <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_MUL: begin
                    r_acc <= w_acc_nxt;
                    r_q   <= r_q << 1;
                    r_cnt <= r_cnt + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_lcm_unit.sv
// Bench for gcd_lcm_unit: directed cases plus randomized regression at
// WIDTH=16 and WIDTH=8 against a Euclid-based arithmetic reference.
module tb_gcd_lcm_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start16 = 1'b0;
    logic        mode16  = 1'b0;
    logic [15:0] a16 = '0;
    logic [15:0] b16 = '0;
    logic        busy16;
    logic        done16;
    logic [31:0] result16;
    logic        err16;

    logic        start8 = 1'b0;
    logic        mode8  = 1'b0;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic        busy8;
    logic        done8;
    logic [15:0] result8;
    logic        err8;

    int n_checks = 0;
    int n_errors = 0;
    int n_acc16 = 0, n_done16 = 0, n_acc8 = 0, n_done8 = 0;
    int n_killed16 = 0;

    gcd_lcm_unit #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst(rst), .start(start16), .mode(mode16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .result(result16), .err(err16)
    );

    gcd_lcm_unit #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .mode(mode8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .result(result8), .err(err8)
    );

    always #5 clk = ~clk;

    // Accepted starts counted at the sampling edge; done pulses per cycle.
    always @(posedge clk) begin
        if (!rst && start16 && !busy16) n_acc16++;
        if (!rst && start8 && !busy8) n_acc8++;
    end
    always @(negedge clk) begin
        if (done16) n_done16++;
        if (done8) n_done8++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint unsigned ref_gcd(input longint unsigned x, input longint unsigned y);
        longint unsigned t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    function automatic longint unsigned ref_result(input bit m, input longint unsigned x, input longint unsigned y);
        if (!m) return ref_gcd(x, y);
        if (x == 0 || y == 0) return 0;
        return (x / ref_gcd(x, y)) * y;
    endfunction

    // Latency is measured in cycles after the accepting edge.
    function automatic bit lat_ok(input int w, input bit m, input bit zero, input int lat);
        int s;
        if (zero) return lat == 1;
        s = m ? lat - 2 * w - 1 : lat - 1;
        return (s >= 1) && (s <= 2 * w + 1);
    endfunction

    // Called at the negedge on which start16 was raised; returns at the
    // negedge of the DONE cycle. inject>0 pulses a stray start mid-run.
    task automatic wait16(input int inject, output int lat, output logic [31:0] res,
                          output logic e, output int busy_low, output logic busy_at_done);
        busy_low = 0;
        @(negedge clk);
        start16 = 1'b0;
        lat = 1;
        while (!done16 && lat < 200) begin
            if (!busy16) busy_low++;
            if (lat == inject) begin
                start16 = 1'b1; mode16 = 1'b0; a16 = 16'd7; b16 = 16'd3;
            end else begin
                start16 = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        if (!done16) chk("timeout16", 1'b0, 1'b1);
        res = result16;
        e = err16;
        busy_at_done = busy16;
    endtask

    task automatic wait8(output int lat, output logic [15:0] res, output logic e,
                         output int busy_low, output logic busy_at_done);
        busy_low = 0;
        @(negedge clk);
        start8 = 1'b0;
        lat = 1;
        while (!done8 && lat < 200) begin
            if (!busy8) busy_low++;
            @(negedge clk);
            lat++;
        end
        if (!done8) chk("timeout8", 1'b0, 1'b1);
        res = result8;
        e = err8;
        busy_at_done = busy8;
    endtask

    task automatic op16(input string tag, input bit m, input logic [15:0] x, input logic [15:0] y,
                        input bool_chain, input int inject, output int lat);
        logic [31:0] res;
        logic e, bd;
        int bl;
        if (!bool_chain) @(negedge clk);
        start16 = 1'b1; mode16 = m; a16 = x; b16 = y;
        wait16(inject, lat, res, e, bl, bd);
        chk({tag, "_res"}, res, ref_result(m, x, y));
        chk({tag, "_err"}, e, (!m && x == 0 && y == 0));
        chk({tag, "_busydone"}, bd, 1'b0);
    endtask

    function automatic logic [15:0] pick(input int w);
        int sel;
        logic [15:0] mx;
        mx = 16'((32'd1 << w) - 1);
        sel = $urandom_range(0, 11);
        if (sel == 0) return 16'd0;
        if (sel == 1) return mx;
        if (sel == 2) return mx - 16'd1;
        return 16'($urandom) & mx;
    endfunction

    task automatic rand16(input int n);
        bit chain, m, z;
        logic [15:0] x, y;
        logic [31:0] res;
        logic e, bd;
        int lat, bl, f;
        chain = 1'b0;
        for (int i = 0; i < n; i++) begin
            m = 1'($urandom_range(0, 1));
            x = pick(16);
            y = pick(16);
            if ($urandom_range(0, 3) == 0) begin
                f = $urandom_range(1, 200);
                x = 16'(f * $urandom_range(0, 300));
                y = 16'(f * $urandom_range(1, 300));
            end
            z = (x == 0) || (y == 0);
            if (!chain) @(negedge clk);
            start16 = 1'b1; mode16 = m; a16 = x; b16 = y;
            wait16(0, lat, res, e, bl, bd);
            chk("r16_res", res, ref_result(m, x, y));
            chk("r16_err", e, (!m && x == 0 && y == 0));
            chk("r16_lat", lat_ok(16, m, z, lat), 1'b1);
            chk("r16_busy", (bl == 0) && !bd, 1'b1);
            chain = ($urandom_range(0, 3) == 0);
        end
    endtask

    task automatic rand8(input int n);
        bit chain, m, z;
        logic [7:0] x, y;
        logic [15:0] res;
        logic e, bd;
        int lat, bl;
        chain = 1'b0;
        for (int i = 0; i < n; i++) begin
            m = 1'($urandom_range(0, 1));
            x = 8'(pick(8));
            y = 8'(pick(8));
            z = (x == 0) || (y == 0);
            if (!chain) @(negedge clk);
            start8 = 1'b1; mode8 = m; a8 = x; b8 = y;
            wait8(lat, res, e, bl, bd);
            chk("r8_res", res, ref_result(m, x, y));
            chk("r8_err", e, (!m && x == 0 && y == 0));
            chk("r8_lat", lat_ok(8, m, z, lat), 1'b1);
            chk("r8_busy", (bl == 0) && !bd, 1'b1);
            chain = ($urandom_range(0, 3) == 0);
        end
    endtask

    initial begin
        int lat, cnt;
        logic [31:0] res;
        logic e, bd;
        int bl;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", busy16, 1'b0);
        chk("rst_done", done16, 1'b0);
        chk("rst_result", result16, 32'd0);
        chk("rst_err", err16, 1'b0);

        // gcd(18,12): S=4, done 5 cycles after acceptance.
        op16("gcd18_12", 1'b0, 16'd18, 16'd12, 1'b0, 0, lat);
        chk("gcd18_12_lat", lat, 5);

        // lcm(1000,160): S=10, done at 10+33; stray start mid-run ignored.
        @(negedge clk);
        start16 = 1'b1; mode16 = 1'b1; a16 = 16'd1000; b16 = 16'd160;
        wait16(20, lat, res, e, bl, bd);
        chk("lcm1000_res", res, 32'd4000);
        chk("lcm1000_lat", lat, 43);
        chk("lcm1000_busylow", bl, 0);

        // gcd(3,15) then lcm(3,15) started in the DONE cycle.
        op16("gcd3_15", 1'b0, 16'd3, 16'd15, 1'b0, 0, lat);
        chk("gcd3_15_lat", lat, 4);
        op16("lcm3_15", 1'b1, 16'd3, 16'd15, 1'b1, 0, lat);
        chk("lcm3_15_lat", lat, 36);

        op16("gcd0_0", 1'b0, 16'd0, 16'd0, 1'b0, 0, lat);
        chk("gcd0_0_lat", lat, 1);
        op16("gcd0_7", 1'b0, 16'd0, 16'd7, 1'b0, 0, lat);
        chk("gcd0_7_val", result16, 32'd7);
        op16("lcm0_9", 1'b1, 16'd0, 16'd9, 1'b0, 0, lat);
        op16("lcm_max", 1'b1, 16'd65535, 16'd65534, 1'b0, 0, lat);
        chk("lcm_max_val", result16, 32'd4294770690);

        // Reset during the DIV phase of lcm(1000,160).
        @(negedge clk);
        start16 = 1'b1; mode16 = 1'b1; a16 = 16'd1000; b16 = 16'd160;
        @(negedge clk);
        start16 = 1'b0;
        repeat (14) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_killed16++;
        chk("midrst_busy", busy16, 1'b0);
        chk("midrst_done", done16, 1'b0);
        chk("midrst_result", result16, 32'd0);
        cnt = 0;
        repeat (60) begin
            @(negedge clk);
            if (done16) cnt++;
        end
        chk("midrst_nodone", cnt, 0);
        op16("post_rst_gcd", 1'b0, 16'd18, 16'd12, 1'b0, 0, lat);

        fork
            rand16(1000);
            rand8(1000);
        join

        repeat (3) @(negedge clk);
        chk("done_count16", n_done16, n_acc16 - n_killed16);
        chk("done_count8", n_done8, n_acc8);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
